fetch_sequencer: RTL

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/core_pkg.sv | 13 +
 rtl/fetch_sequencer_if.sv | 25 ++
 rtl/pc_reg.sv | 21 ++
 rtl/fetch_sequencer.sv | 101 ++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the instruction fetch path: FSM encoding, reset PC and the NOP word.
package core_pkg;

  typedef enum logic [1:0] {
    StReq,
    StWait,
    StHold
  } fetch_state_e;

  localparam logic [31:0] ResetPcDefault = 32'h8000_0000;
  localparam logic [31:0] NopInstr       = 32'h0000_0013;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/response bus and the instruction handoff toward decode.
interface fetch_sequencer_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_gnt, imem_rvalid, imem_rdata, instr_ready
  );

endinterface

// File: rtl/pc_reg.sv
// Architectural PC register: loads the next value every cycle, resets to the boot address.
module pc_reg
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = ResetPcDefault
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [31:0] pc_d,
  output logic [31:0] pc_q
);

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Single-outstanding instruction fetch FSM with redirect/trap steering and killed-response drop.
module fetch_sequencer
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = ResetPcDefault
) (
  input  logic                     CLK,
  input  logic                     reset,
  fetch_sequencer_if.master        bus,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  input  logic                     trap_valid,
  input  logic [31:0]              trap_pc,
  output logic [31:0]              pc_q
);

  fetch_state_e state_q, state_d;
  logic         kill_q, kill_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  instr_pc_q, instr_pc_d;
  logic [31:0]  pc_d;
  logic         redir;
  logic [31:0]  target;

  assign redir  = trap_valid | redirect_valid;
  assign target = (trap_valid ? trap_pc : redirect_pc) & 32'hFFFF_FFFC;

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .CLK  (CLK),
    .reset(reset),
    .pc_d (pc_d),
    .pc_q (pc_q)
  );

  always_comb begin
    state_d    = state_q;
    kill_d     = kill_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    pc_d       = pc_q;
    unique case (state_q)
      StReq: begin
        if (bus.imem_gnt) begin
          state_d = StWait;
          kill_d  = redir;
        end
        if (redir) pc_d = target;
      end
      StWait: begin
        if (bus.imem_rvalid) begin
          // A response is only delivered if no redirect has overtaken it.
          if (!kill_q && !redir) begin
            instr_d    = bus.imem_rdata;
            instr_pc_d = pc_q;
            state_d    = StHold;
          end else begin
            state_d = StReq;
          end
          kill_d = 1'b0;
        end else if (redir) begin
          kill_d = 1'b1;
        end
        if (redir) pc_d = target;
      end
      StHold: begin
        if (redir) begin
          pc_d    = target;
          state_d = StReq;
        end else if (bus.instr_ready) begin
          pc_d    = instr_pc_q + 32'd4;
          state_d = StReq;
        end
      end
      default: state_d = StReq;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q    <= StReq;
      kill_q     <= 1'b0;
      instr_q    <= NopInstr;
      instr_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      kill_q     <= kill_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  // Request is masked while reset is held so nothing is issued before release.
  assign bus.imem_req    = reset && (state_q == StReq);
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = (state_q == StHold);
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;

endmodule
